// File: rtl/seq_multiplier.sv
// Shift-add WIDTH x WIDTH multiplier with run-time signed/unsigned mode; result WIDTH+1 cycles after accept.
// One operation in flight: in_ready only in IDLE, product held in DONE until out_ready.
module seq_multiplier #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;

  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      cnt;
  logic               neg;

  logic               accept;
  logic               last_step;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] acc_nxt;

  assign accept    = in_valid && in_ready;
  assign last_step = (state == CALC) && (cnt == CW'(WIDTH - 1));

  // The most negative operand negates to itself, which is its correct unsigned magnitude.
  assign a_mag = (signed_mode && a[WIDTH-1]) ? -a : a;
  assign b_mag = (signed_mode && b[WIDTH-1]) ? -b : b;

  always_comb begin
    sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mplier[0] ? {1'b0, mcand} : '0);
    acc_nxt = (2*WIDTH)'({sum, acc[WIDTH-1:0]} >> 1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_nxt = CALC;
        end
      end
      CALC: begin
        busy = 1'b1;
        if (last_step) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      cnt     <= '0;
      neg     <= 1'b0;
      product <= '0;
    end else if (accept) begin
      mcand  <= a_mag;
      mplier <= b_mag;
      neg    <= signed_mode && (a[WIDTH-1] ^ b[WIDTH-1]);
      acc    <= '0;
      cnt    <= '0;
    end else if (state == CALC) begin
      acc    <= acc_nxt;
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
      // Sign is applied once to the finished magnitude product.
      if (last_step) begin
        product <= neg ? -acc_nxt : acc_nxt;
      end
    end
  end

endmodule
